video_frame_checker: RTL and testbench
======================================

# video_frame_checker

Self-checking monitor in the clk2 (1080p) domain that consumes the 27-bit output bus of the bilinear super-resolution block (BS, DPo) in parallel with image_capture. Per frame it measures the active width and height, compares them against the programmed Hsize/Vsize, and computes a CRC-32 over all active pixels. Results are reported once per frame so regressions can compare a signature instead of a BMP dump.

## Interface
Parameters:
- CNT_W_H, 12, width of the pixel-per-line counter; matches Hsize.
- CNT_W_V, 11, width of the line counter; matches Vsize.

Ports:
- clk  in  1  pixel clock (clk2 domain, 148.5 MHz nominal).
- rst  in  1  reset; synchronous, active-high.
- DPi  in  27  video bus; [26]=VS, [25]=HS, [24]=DE, [23:0]=RGB (R in [23:16]).
- Hsize  in  12  expected active pixels per line; quasi-static.
- Vsize  in  11  expected active lines per frame; quasi-static.
- frame_done  out  1  one-cycle pulse; results are valid from this cycle until the next pulse.
- meas_width  out  12  pixel count of the last line of the reported frame.
- meas_height  out  11  active line count of the reported frame.
- width_err  out  1  at least one line in the reported frame had a pixel count ≠ Hsize.
- height_err  out  1  meas_height ≠ Vsize.
- first_err_line  out  11  index (0-based) of the first line with a width error; 0 when width_err=0.
- frame_crc  out  32  CRC-32 of the reported frame.
- frame_cnt  out  16  number of frames reported since reset; wraps at 65535→0.

## Operation
- Input stage: DPi registered into d1; d1 registered into d2. All edges are detected as d1 vs d2.
- VS rise = d1[26]&!d2[26]. DE fall = !d1[24]&d2[24].
- FSM states:
  - IDLE: accumulators cleared. VS rise → ACTIVE.
  - ACTIVE: accumulate. VS rise → REPORT.
  - REPORT: one cycle. Latch results, pulse frame_done, clear accumulators, → ACTIVE.
  - A partial frame after reset is never reported.
- Pixel accumulation in ACTIVE:
  - Each cycle with d1[24]=1, pix_cnt increments, saturating at 4095.
  - The CRC is updated with d1[23:0], processed as 3 bytes: R, then G, then B, MSB-first.
- CRC: polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, final XOR 0xFFFFFFFF (CRC-32/BZIP2). The 24-bit update is completed in one cycle (unrolled).
- Line end (DE fall):
  - Compare pix_cnt to Hsize. On mismatch, set the sticky width error; if it is the first error in the frame, capture line_cnt as the error line.
  - line_cnt increments, saturating at 2047.
  - last_width ← pix_cnt; pix_cnt ← 0.
- Truncated line: if DE is still 1 (d1[24]=1) when VS rises, the open line is closed as if DE fell. It is counted and width-checked, and counts toward the closing frame.
- Simultaneous events: a DE fall and a VS rise in the same cycle close the line first; the line belongs to the closing frame.
- HS is ignored for counting; only DE delimits lines.
- Pixels with DE=1 in the REPORT cycle are accumulated into the new frame. The pixel/CRC path runs independently of the clear.
- Hsize and Vsize are sampled at the REPORT cycle for height_err, and continuously for the per-line check.
- Reset (any cycle, including mid-frame): FSM → IDLE; d1, d2, accumulators and all outputs → 0.

## Timing
- Reset values: frame_done=0, meas_width=0, meas_height=0, width_err=0, height_err=0, first_err_line=0, frame_crc=0, frame_cnt=0.
- Latency: if DPi[26] first samples 1 at clk edge k, then:
  - d1 at edge k, VS rise detected during cycle k.
  - REPORT at edge k+1.
  - frame_done high from edge k+1 to k+2, with all result outputs updated at edge k+1.
- Result outputs hold between pulses; no handshake and no backpressure.
- frame_cnt increments at the same edge frame_done rises.
- Throughput: one pixel per clk, with no stalls at any DE duty cycle.
- Minimum VS period: 3 clk. Shorter periods are out of scope.

## Test plan
- Nominal 1920×1080 frame (timing per timing_generator: h_total 2200, v_total 1125), RGB = pixel x coordinate; two VS rises → frame_done once, meas_width=1920, meas_height=1080, width_err=0, height_err=0, frame_cnt=1. Same frame repeated → identical frame_crc.
- CRC vector: Hsize=3, Vsize=1, one line of pixels 0x313233, 0x343536, 0x373839 → frame_crc=0xFC891918, errors=0.
- Line 500 carries 1919 pixels, line 700 carries 1921 → width_err=1, first_err_line=500, height_err=0, meas_height=1080.
- 1079 active lines → height_err=1, meas_height=1079. Next correct frame → height_err=0.
- Reset asserted for 2 clk during line 300 → all outputs 0 within 1 clk. The first VS after release produces no frame_done; the second VS reports a complete frame with frame_cnt=1.
- DE held high across a VS rise (last line 1000 pixels) → that line is counted, width_err=1, and the next frame starts clean.

Source files
------------

// File: rtl/video_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : video_frame_checker
// Brief    : Per-frame width/height measurement and CRC-32/BZIP2 signature
//            of the 27-bit super-resolution output bus.
// Revision : 1.0
// ============================================================================
module video_frame_checker #(
  parameter int CNT_W_H = 12,
  parameter int CNT_W_V = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [26:0]        DPi,
  input  logic [CNT_W_H-1:0] Hsize,
  input  logic [CNT_W_V-1:0] Vsize,
  output logic               frame_done,
  output logic [CNT_W_H-1:0] meas_width,
  output logic [CNT_W_V-1:0] meas_height,
  output logic               width_err,
  output logic               height_err,
  output logic [CNT_W_V-1:0] first_err_line,
  output logic [31:0]        frame_crc,
  output logic [15:0]        frame_cnt
);

  localparam logic [1:0]         S_IDLE   = 2'd0;
  localparam logic [1:0]         S_ACTIVE = 2'd1;
  localparam logic [1:0]         S_REPORT = 2'd2;
  localparam logic [31:0]        CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0]        CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [CNT_W_H-1:0] PIX_MAX  = '1;
  localparam logic [CNT_W_V-1:0] LINE_MAX = '1;

  // MSB-first, non-reflected update over R, G, B in one cycle
  function automatic logic [31:0] crc_upd24(input logic [31:0] c, input logic [23:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  logic [26:0]        d1_q;
  logic [1:0]         d2_q;       // only VS and DE of the second stage are needed
  logic [1:0]         state_q, state_d;
  logic [CNT_W_H-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W_V-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W_H-1:0] last_w_q, last_w_d;
  logic               werr_q, werr_d;
  logic [CNT_W_V-1:0] fel_q, fel_d;
  logic [31:0]        crc_q, crc_d;

  logic               frame_done_q, frame_done_d;
  logic [CNT_W_H-1:0] meas_width_q, meas_width_d;
  logic [CNT_W_V-1:0] meas_height_q, meas_height_d;
  logic               width_err_q, width_err_d;
  logic               height_err_q, height_err_d;
  logic [CNT_W_V-1:0] first_err_line_q, first_err_line_d;
  logic [31:0]        frame_crc_q, frame_crc_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               w_de, w_vs_rise, w_de_fall, w_run, w_close, w_end_frame;
  logic [CNT_W_H-1:0] w_pix_inc, w_pix_next;
  logic               unused_hs;

  assign unused_hs   = d1_q[25];
  assign w_de        = d1_q[24];
  assign w_vs_rise   = d1_q[26] & ~d2_q[1];
  assign w_de_fall   = ~d1_q[24] & d2_q[0];
  assign w_run       = (state_q != S_IDLE);
  assign w_pix_inc   = (pix_cnt_q == PIX_MAX) ? pix_cnt_q : pix_cnt_q + 1'b1;
  assign w_pix_next  = w_de ? w_pix_inc : pix_cnt_q;
  // An empty close only happens right after a truncated line was already closed.
  assign w_close     = w_run && (w_de_fall || (w_vs_rise && w_de)) && (w_pix_next != '0);
  assign w_end_frame = (state_q == S_ACTIVE) && w_vs_rise;

  always_comb begin
    state_d          = state_q;
    pix_cnt_d        = pix_cnt_q;
    line_cnt_d       = line_cnt_q;
    last_w_d         = last_w_q;
    werr_d           = werr_q;
    fel_d            = fel_q;
    crc_d            = crc_q;
    frame_done_d     = 1'b0;
    meas_width_d     = meas_width_q;
    meas_height_d    = meas_height_q;
    width_err_d      = width_err_q;
    height_err_d     = height_err_q;
    first_err_line_d = first_err_line_q;
    frame_crc_d      = frame_crc_q;
    frame_cnt_d      = frame_cnt_q;

    if (w_run) begin
      if (w_de) begin
        pix_cnt_d = w_pix_inc;
        crc_d     = crc_upd24(crc_q, d1_q[23:0]);
      end
      if (w_close) begin
        pix_cnt_d  = '0;
        last_w_d   = w_pix_next;
        line_cnt_d = (line_cnt_q == LINE_MAX) ? line_cnt_q : line_cnt_q + 1'b1;
        if (w_pix_next != Hsize) begin
          werr_d = 1'b1;
          if (!werr_q) fel_d = line_cnt_q;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        pix_cnt_d  = '0;
        line_cnt_d = '0;
        last_w_d   = '0;
        werr_d     = 1'b0;
        fel_d      = '0;
        crc_d      = CRC_INIT;
        if (w_vs_rise) state_d = S_ACTIVE;
      end
      S_ACTIVE: if (w_vs_rise) state_d = S_REPORT;
      S_REPORT: state_d = S_ACTIVE;
      default:  state_d = S_IDLE;
    endcase

    // Results are latched on entry to REPORT so they appear one edge after VS rise.
    if (w_end_frame) begin
      frame_done_d     = 1'b1;
      meas_width_d     = last_w_d;
      meas_height_d    = line_cnt_d;
      width_err_d      = werr_d;
      height_err_d     = (line_cnt_d != Vsize);
      first_err_line_d = fel_d;
      frame_crc_d      = ~crc_d;
      frame_cnt_d      = frame_cnt_q + 16'd1;
      pix_cnt_d        = '0;
      line_cnt_d       = '0;
      last_w_d         = '0;
      werr_d           = 1'b0;
      fel_d            = '0;
      crc_d            = CRC_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q             <= '0;
      d2_q             <= '0;
      state_q          <= S_IDLE;
      pix_cnt_q        <= '0;
      line_cnt_q       <= '0;
      last_w_q         <= '0;
      werr_q           <= 1'b0;
      fel_q            <= '0;
      crc_q            <= '0;
      frame_done_q     <= 1'b0;
      meas_width_q     <= '0;
      meas_height_q    <= '0;
      width_err_q      <= 1'b0;
      height_err_q     <= 1'b0;
      first_err_line_q <= '0;
      frame_crc_q      <= '0;
      frame_cnt_q      <= '0;
    end else begin
      d1_q             <= DPi;
      d2_q             <= {d1_q[26], d1_q[24]};
      state_q          <= state_d;
      pix_cnt_q        <= pix_cnt_d;
      line_cnt_q       <= line_cnt_d;
      last_w_q         <= last_w_d;
      werr_q           <= werr_d;
      fel_q            <= fel_d;
      crc_q            <= crc_d;
      frame_done_q     <= frame_done_d;
      meas_width_q     <= meas_width_d;
      meas_height_q    <= meas_height_d;
      width_err_q      <= width_err_d;
      height_err_q     <= height_err_d;
      first_err_line_q <= first_err_line_d;
      frame_crc_q      <= frame_crc_d;
      frame_cnt_q      <= frame_cnt_d;
    end
  end

  assign frame_done     = frame_done_q;
  assign meas_width     = meas_width_q;
  assign meas_height    = meas_height_q;
  assign width_err      = width_err_q;
  assign height_err     = height_err_q;
  assign first_err_line = first_err_line_q;
  assign frame_crc      = frame_crc_q;
  assign frame_cnt      = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_frame_checker
// Brief    : Table-driven frame scenarios with a result scoreboard.
// Revision : 1.0
// ============================================================================
module tb_video_frame_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] DPi;
  logic [11:0] Hsize;
  logic [10:0] Vsize;
  logic        frame_done;
  logic [11:0] meas_width;
  logic [10:0] meas_height;
  logic        width_err, height_err;
  logic [10:0] first_err_line;
  logic [31:0] frame_crc;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  video_frame_checker #(.CNT_W_H(12), .CNT_W_V(11)) dut (
    .clk(clk), .rst(rst), .DPi(DPi), .Hsize(Hsize), .Vsize(Vsize),
    .frame_done(frame_done), .meas_width(meas_width), .meas_height(meas_height),
    .width_err(width_err), .height_err(height_err), .first_err_line(first_err_line),
    .frame_crc(frame_crc), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int hsize, vsize, nlines, bad_a, wa, bad_b, wb, trunc_w, tail, pat;
    int e_width, e_height, e_werr, e_herr, e_fel;
    logic [31:0] e_crc;   // 0: take the CRC from the reference model
  } vec_t;

  typedef struct {
    logic [11:0] width;
    logic [10:0] height;
    logic        werr, herr;
    logic [10:0] fel;
    logic [31:0] crc;
    logic [15:0] cnt;
  } exp_t;

  localparam int NVEC = 9;
  vec_t        vecs[NVEC];
  exp_t        sb[$];
  exp_t        cur_exp;
  logic        cur_use_tbl;
  logic [31:0] cur_tbl_crc;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_crc;
  logic        m_active, m_prev_vs;
  int          m_cnt;

  // Byte-serial reference CRC-32/BZIP2 (no final XOR applied here)
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [23:0] px);
    logic [31:0] r;
    logic [7:0]  b;
    r = c;
    for (int k = 2; k >= 0; k--) begin
      b = px[k*8 +: 8];
      r = r ^ {b, 24'h0};
      for (int j = 0; j < 8; j++)
        r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    end
    return r;
  endfunction

  function automatic logic [23:0] pix(input int pat, input int x, input int y);
    logic [7:0] b0;
    if (pat == 1) begin
      b0 = 8'(8'h31 + 3 * x);
      return {b0, b0 + 8'd1, b0 + 8'd2};
    end
    return {8'(y * 7), 16'(x)};
  endfunction

  function automatic int line_w(input int r, input int y);
    if (y == vecs[r].bad_a) return vecs[r].wa;
    if (y == vecs[r].bad_b) return vecs[r].wb;
    return vecs[r].hsize;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle; the model sees the same sequence the DUT samples.
  task automatic drive(input logic vs, input logic hs, input logic de, input logic [23:0] rgb);
    DPi = {vs, hs, de, rgb};
    @(posedge clk);
    if (vs && !m_prev_vs) begin
      if (m_active) begin
        if (de) m_crc = ref_crc(m_crc, rgb);
        cur_exp.crc = cur_use_tbl ? cur_tbl_crc : ~m_crc;
        m_cnt++;
        cur_exp.cnt = 16'(m_cnt);
        sb.push_back(cur_exp);
        m_crc = 32'hFFFF_FFFF;
      end else begin
        m_active = 1'b1;
      end
    end else if (m_active && de) begin
      m_crc = ref_crc(m_crc, rgb);
    end
    m_prev_vs = vs;
  endtask

  task automatic vs_edge(input logic de, input logic [23:0] rgb);
    drive(1'b1, 1'b0, de, rgb);
    drive(1'b1, 1'b0, 1'b0, 24'h0);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic run_frame(input int r);
    int w;
    Hsize          = 12'(vecs[r].hsize);
    Vsize          = 11'(vecs[r].vsize);
    cur_exp.width  = 12'(vecs[r].e_width);
    cur_exp.height = 11'(vecs[r].e_height);
    cur_exp.werr   = (vecs[r].e_werr != 0);
    cur_exp.herr   = (vecs[r].e_herr != 0);
    cur_exp.fel    = 11'(vecs[r].e_fel);
    cur_use_tbl    = (vecs[r].e_crc != 32'h0);
    cur_tbl_crc    = vecs[r].e_crc;
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    for (int y = 0; y < vecs[r].nlines; y++) begin
      w = (y == vecs[r].nlines - 1 && vecs[r].trunc_w > 0) ? vecs[r].trunc_w - 1 : line_w(r, y);
      drive(1'b0, 1'b1, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      for (int x = 0; x < w; x++) drive(1'b0, 1'b0, 1'b1, pix(vecs[r].pat, x, y));
    end
    if (vecs[r].trunc_w == 0)
      for (int t = 0; t < vecs[r].tail; t++) drive(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    check({tag, "_meas_width"}, 32'(meas_width), 32'h0);
    check({tag, "_meas_height"}, 32'(meas_height), 32'h0);
    check({tag, "_width_err"}, 32'(width_err), 32'h0);
    check({tag, "_height_err"}, 32'(height_err), 32'h0);
    check({tag, "_first_err_line"}, 32'(first_err_line), 32'h0);
    check({tag, "_frame_crc"}, frame_crc, 32'h0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && frame_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_done: got frame_done=1 frame_cnt=%0d expected no report", frame_cnt);
      end else begin
        e = sb.pop_front();
        check("meas_width", 32'(meas_width), 32'(e.width));
        check("meas_height", 32'(meas_height), 32'(e.height));
        check("width_err", 32'(width_err), 32'(e.werr));
        check("height_err", 32'(height_err), 32'(e.herr));
        check("first_err_line", 32'(first_err_line), 32'(e.fel));
        check("frame_crc", frame_crc, e.crc);
        check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    //            hs  vs  nl bada wa badb wb trw tail pat  ew  eh werr herr fel crc
    vecs[0] = '{16, 10, 10, -1,  0, -1,  0,  0, 4, 0,  16, 10, 0, 0, 0, 32'h0};
    vecs[1] = '{16, 10, 10, -1,  0, -1,  0,  0, 4, 0,  16, 10, 0, 0, 0, 32'h0};
    vecs[2] = '{16, 10, 10,  5, 15,  7, 17,  0, 4, 0,  16, 10, 1, 0, 5, 32'h0};
    vecs[3] = '{16, 10,  9, -1,  0, -1,  0,  0, 4, 0,  16,  9, 0, 1, 0, 32'h0};
    vecs[4] = '{16, 10, 10, -1,  0, -1,  0,  0, 4, 0,  16, 10, 0, 0, 0, 32'h0};
    vecs[5] = '{ 3,  1,  1, -1,  0, -1,  0,  0, 4, 1,   3,  1, 0, 0, 0, 32'hFC891918};
    vecs[6] = '{16, 10, 10, -1,  0, -1,  0, 12, 0, 0,  12, 10, 1, 0, 9, 32'h0};
    vecs[7] = '{16, 10, 10, -1,  0, -1,  0,  0, 0, 0,  16, 10, 0, 0, 0, 32'h0};
    vecs[8] = '{16, 10, 10,  0, 20, -1,  0,  0, 4, 0,  16, 10, 1, 0, 0, 32'h0};

    rst = 1'b1;
    DPi = '0;
    Hsize = 12'd16;
    Vsize = 11'd10;
    m_crc = 32'hFFFF_FFFF;
    m_active = 1'b0;
    m_prev_vs = 1'b0;
    m_cnt = 0;
    cur_exp = '{default: '0};
    cur_use_tbl = 1'b0;
    cur_tbl_crc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);

    vs_edge(1'b0, 24'h0);
    for (int r = 0; r < NVEC; r++) begin
      run_frame(r);
      vs_edge(vecs[r].trunc_w > 0, pix(vecs[r].pat, vecs[r].trunc_w - 1, vecs[r].nlines - 1));
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("sb_drained_before_reset", 32'(sb.size()), 32'h0);

    // Mid-line reset held for two cycles
    for (int x = 0; x < 6; x++) drive(1'b0, 1'b0, 1'b1, pix(0, x, 0));
    DPi = {3'b001, 24'h123456};
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk);
    rst = 1'b0;
    DPi = '0;
    m_crc = 32'hFFFF_FFFF;
    m_active = 1'b0;
    m_prev_vs = 1'b0;
    m_cnt = 0;
    repeat (2) drive(1'b0, 1'b0, 1'b0, 24'h0);
    vs_edge(1'b0, 24'h0);
    run_frame(0);
    vs_edge(1'b0, 24'h0);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("sb_drained_at_end", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
